// File: rtl/mips_pkg.sv
// Shared encodings, ALU operation set and helpers for the Harvard MIPS32 subset core.
package mips_pkg;

  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'hBFC0_0000;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0A;
  localparam logic [5:0] OP_SLTIU   = 6'h0B;
  localparam logic [5:0] OP_ANDI    = 6'h0C;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_XORI    = 6'h0E;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2B;

  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_JR   = 6'h08;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A;
  localparam logic [5:0] F_SLTU = 6'h2B;

  typedef enum logic [3:0] {
    AluAdd, AluSub, AluAnd, AluOr, AluXor, AluNor,
    AluSlt, AluSltu, AluSll, AluSrl, AluSra, AluLui
  } alu_op_e;

  // Bus words carry bytes in the opposite order to register values.
  function automatic logic [31:0] byte_swap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/mips_regfile.sv
// 32x32 general-purpose register file: two combinational read ports, one write port.
module mips_regfile (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  raddr_a,
  output logic [31:0] rdata_a,
  input  logic [4:0]  raddr_b,
  output logic [31:0] rdata_b,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  output logic [31:0] v0
);

  logic [31:0] regs_q [32];

  // $0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we && (waddr != 5'd0)) begin
      regs_q[waddr] <= wdata;
    end
  end

  assign rdata_a = regs_q[raddr_a];
  assign rdata_b = regs_q[raddr_b];
  assign v0      = regs_q[2];

endmodule

// File: rtl/mips_harvard_cpu.sv
// Single-cycle MIPS32 subset core with separate instruction/data buses and branch delay slots.
module mips_harvard_cpu
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_enable,
  output logic        active,
  output logic [31:0] register_v0,
  output logic [31:0] instr_address,
  input  logic [31:0] instr_readdata,
  output logic [31:0] data_address,
  output logic        data_write,
  output logic        data_read,
  output logic [31:0] data_writedata,
  input  logic [31:0] data_readdata
);

  logic [31:0] pc_q, npc_q, npc_d;
  logic        active_q;
  logic        step;

  logic [31:0] instr;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm;
  logic [25:0] idx;
  logic [31:0] imm_sext, imm_zext;

  assign instr    = byte_swap32(instr_readdata);
  assign opcode   = instr[31:26];
  assign rs       = instr[25:21];
  assign rt       = instr[20:16];
  assign rd       = instr[15:11];
  assign shamt    = instr[10:6];
  assign funct    = instr[5:0];
  assign imm      = instr[15:0];
  assign idx      = instr[25:0];
  assign imm_sext = {{16{imm[15]}}, imm};
  assign imm_zext = {16'h0000, imm};

  assign step = clk_enable & active_q;

  logic [31:0] rs_val, rt_val, v0_val, wb_data;
  logic        rf_we, rf_we_dec;
  logic [4:0]  rf_waddr;

  mips_regfile u_regfile (
    .clk     (clk),
    .reset   (reset),
    .raddr_a (rs),
    .rdata_a (rs_val),
    .raddr_b (rt),
    .rdata_b (rt_val),
    .we      (rf_we),
    .waddr   (rf_waddr),
    .wdata   (wb_data),
    .v0      (v0_val)
  );

  alu_op_e alu_op;
  logic    src_imm, zext_imm;
  logic    is_lw, is_sw, is_beq, is_bne, is_j, is_jal, is_jr;

  always_comb begin
    alu_op    = AluAdd;
    src_imm   = 1'b0;
    zext_imm  = 1'b0;
    rf_we_dec = 1'b0;
    rf_waddr  = rd;
    is_lw     = 1'b0;
    is_sw     = 1'b0;
    is_beq    = 1'b0;
    is_bne    = 1'b0;
    is_j      = 1'b0;
    is_jal    = 1'b0;
    is_jr     = 1'b0;
    case (opcode)
      OP_SPECIAL: begin
        rf_we_dec = 1'b1;
        case (funct)
          F_ADDU:  alu_op = AluAdd;
          F_SUBU:  alu_op = AluSub;
          F_AND:   alu_op = AluAnd;
          F_OR:    alu_op = AluOr;
          F_XOR:   alu_op = AluXor;
          F_NOR:   alu_op = AluNor;
          F_SLT:   alu_op = AluSlt;
          F_SLTU:  alu_op = AluSltu;
          F_SLL:   alu_op = AluSll;
          F_SRL:   alu_op = AluSrl;
          F_SRA:   alu_op = AluSra;
          F_JR: begin
            rf_we_dec = 1'b0;
            is_jr     = 1'b1;
          end
          default: rf_we_dec = 1'b0;
        endcase
      end
      OP_ADDIU: begin src_imm = 1'b1; rf_waddr = rt; rf_we_dec = 1'b1; end
      OP_SLTI:  begin src_imm = 1'b1; rf_waddr = rt; rf_we_dec = 1'b1; alu_op = AluSlt; end
      OP_SLTIU: begin src_imm = 1'b1; rf_waddr = rt; rf_we_dec = 1'b1; alu_op = AluSltu; end
      OP_ANDI: begin
        src_imm = 1'b1; zext_imm = 1'b1; rf_waddr = rt; rf_we_dec = 1'b1; alu_op = AluAnd;
      end
      OP_ORI: begin
        src_imm = 1'b1; zext_imm = 1'b1; rf_waddr = rt; rf_we_dec = 1'b1; alu_op = AluOr;
      end
      OP_XORI: begin
        src_imm = 1'b1; zext_imm = 1'b1; rf_waddr = rt; rf_we_dec = 1'b1; alu_op = AluXor;
      end
      OP_LUI:   begin rf_waddr = rt; rf_we_dec = 1'b1; alu_op = AluLui; end
      OP_LW:    begin rf_waddr = rt; rf_we_dec = 1'b1; is_lw = 1'b1; end
      OP_SW:    is_sw = 1'b1;
      OP_BEQ:   is_beq = 1'b1;
      OP_BNE:   is_bne = 1'b1;
      OP_J:     is_j = 1'b1;
      OP_JAL:   begin rf_waddr = 5'd31; rf_we_dec = 1'b1; is_jal = 1'b1; end
      default:  ;
    endcase
  end

  logic [31:0] op_b, alu_res;
  assign op_b = src_imm ? (zext_imm ? imm_zext : imm_sext) : rt_val;

  always_comb begin
    alu_res = '0;
    case (alu_op)
      AluAdd:  alu_res = rs_val + op_b;
      AluSub:  alu_res = rs_val - op_b;
      AluAnd:  alu_res = rs_val & op_b;
      AluOr:   alu_res = rs_val | op_b;
      AluXor:  alu_res = rs_val ^ op_b;
      AluNor:  alu_res = ~(rs_val | op_b);
      AluSlt:  alu_res = {31'b0, $signed(rs_val) < $signed(op_b)};
      AluSltu: alu_res = {31'b0, rs_val < op_b};
      AluSll:  alu_res = rt_val << shamt;
      AluSrl:  alu_res = rt_val >> shamt;
      AluSra:  alu_res = $signed(rt_val) >>> shamt;
      AluLui:  alu_res = {imm, 16'h0000};
      default: alu_res = '0;
    endcase
  end

  assign wb_data = is_lw  ? byte_swap32(data_readdata) :
                   is_jal ? pc_q + 32'd8 : alu_res;
  assign rf_we   = rf_we_dec & step;

  // Strobes are also masked while reset is held, since the ROM may present a store at the vector.
  assign data_address   = rs_val + imm_sext;
  assign data_writedata = byte_swap32(rt_val);
  assign data_read      = is_lw & step & reset;
  assign data_write     = is_sw & step & reset;

  logic branch_taken;
  assign branch_taken = (is_beq && (rs_val == rt_val)) || (is_bne && (rs_val != rt_val));

  // npc_q is the delay-slot PC; redirects replace the instruction that follows the slot.
  always_comb begin
    npc_d = npc_q + 32'd4;
    if (branch_taken) begin
      npc_d = npc_q + {imm_sext[29:0], 2'b00};
    end else if (is_j || is_jal) begin
      npc_d = {npc_q[31:28], idx, 2'b00};
    end else if (is_jr) begin
      npc_d = rs_val;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q     <= RESET_VECTOR;
      npc_q    <= RESET_VECTOR + 32'd4;
      active_q <= 1'b1;
    end else if (step) begin
      pc_q  <= npc_q;
      npc_q <= npc_d;
      if (npc_q == 32'd0) begin
        active_q <= 1'b0;
      end
    end
  end

  assign instr_address = pc_q;
  assign active        = active_q;
  assign register_v0   = v0_val;

endmodule

// File: tb/tb_mips_harvard_cpu.sv
// Directed self-checking bench: ROM/RAM models, hand-assembled programs, per-feature tasks.
module tb_mips_harvard_cpu;

  localparam logic [31:0] RV = 32'hBFC0_0000;

  localparam logic [5:0] O_J = 6'h02, O_JAL = 6'h03, O_BEQ = 6'h04, O_BNE = 6'h05;
  localparam logic [5:0] O_ADDIU = 6'h09, O_SLTI = 6'h0A, O_SLTIU = 6'h0B, O_ANDI = 6'h0C;
  localparam logic [5:0] O_ORI = 6'h0D, O_XORI = 6'h0E, O_LUI = 6'h0F, O_LW = 6'h23;
  localparam logic [5:0] O_SW = 6'h2B;
  localparam logic [5:0] FN_SLL = 6'h00, FN_SRL = 6'h02, FN_SRA = 6'h03, FN_JR = 6'h08;
  localparam logic [5:0] FN_ADDU = 6'h21, FN_SUBU = 6'h23, FN_AND = 6'h24, FN_OR = 6'h25;
  localparam logic [5:0] FN_XOR = 6'h26, FN_NOR = 6'h27, FN_SLT = 6'h2A, FN_SLTU = 6'h2B;

  logic        clk = 1'b0;
  logic        reset;
  logic        clk_enable;
  logic        active;
  logic [31:0] register_v0, instr_address, instr_readdata;
  logic [31:0] data_address, data_writedata, data_readdata;
  logic        data_write, data_read;

  logic [31:0] rom  [256];
  logic [31:0] dram [1024];
  logic [31:0] rom_off;

  int checks = 0;
  int errors = 0;

  mips_harvard_cpu dut (
    .clk            (clk),
    .reset          (reset),
    .clk_enable     (clk_enable),
    .active         (active),
    .register_v0    (register_v0),
    .instr_address  (instr_address),
    .instr_readdata (instr_readdata),
    .data_address   (data_address),
    .data_write     (data_write),
    .data_read      (data_read),
    .data_writedata (data_writedata),
    .data_readdata  (data_readdata)
  );

  always #5 clk = ~clk;

  assign rom_off        = instr_address - RV;
  assign instr_readdata = (rom_off < 32'd1024) ? rom[rom_off[9:2]] : 32'h0;
  assign data_readdata  = dram[data_address[11:2]];

  always @(posedge clk) begin
    if (data_write) dram[data_address[11:2]] = data_writedata;
  end

  function automatic logic [31:0] bswap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh,
                                        input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [31:0] target);
    logic [31:0] t;
    t = target >> 2;
    return {op, t[25:0]};
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) rom[i] = 32'h0;
    for (int i = 0; i < 1024; i++) dram[i] = 32'h0;
  endtask

  task automatic load(input int i, input logic [31:0] ins);
    rom[i] = bswap(ins);
  endtask

  task automatic do_reset();
    clk_enable = 1'b1;
    reset = 1'b1;
    #1;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic run_to_halt(input int max_cycles, output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < max_cycles; i++) begin
      if (!active) break;
      @(negedge clk);
    end
    if (!active) timed_out = 1'b0;
  endtask

  task automatic test_reset();
    clear_mem();
    load(0, enc_r(5'd0, 5'd0, 5'd0, 5'd0, FN_JR));
    clk_enable = 1'b1;
    reset = 1'b1;
    #1;
    reset = 1'b0;
    #2;
    checks++;
    if (instr_address !== RV) begin
      errors++; $display("FAIL reset_pc: got %h expected %h", instr_address, RV);
    end
    checks++;
    if (active !== 1'b1 || data_write !== 1'b0 || data_read !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: got act=%b wr=%b rd=%b expected 1 0 0",
               active, data_write, data_read);
    end
    checks++;
    if (register_v0 !== 32'h0) begin
      errors++; $display("FAIL reset_v0: got %h expected 0", register_v0);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (active !== 1'b1 || instr_address !== RV + 32'd4) begin
      errors++;
      $display("FAIL halt_cycle1: got act=%b pc=%h expected 1 %h", active, instr_address,
               RV + 32'd4);
    end
    @(negedge clk);
    checks++;
    if (active !== 1'b0 || instr_address !== 32'h0) begin
      errors++; $display("FAIL halt_cycle2: got act=%b pc=%h expected 0 0", active, instr_address);
    end
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (active !== 1'b0 || instr_address !== 32'h0 || data_write !== 1'b0) begin
        errors++;
        $display("FAIL halt_hold: got act=%b pc=%h wr=%b expected 0 0 0",
                 active, instr_address, data_write);
      end
    end
  endtask

  task automatic test_addiu();
    logic [31:0] exp [8] = '{32'h12340000, 32'h12345678, 32'h12345679, 32'h12345678,
                             32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    clear_mem();
    load(0, enc_i(O_LUI, 5'd0, 5'd2, 16'h1234));
    load(1, enc_i(O_ORI, 5'd2, 5'd2, 16'h5678));
    load(2, enc_i(O_ADDIU, 5'd2, 5'd2, 16'h0001));
    load(3, enc_i(O_ADDIU, 5'd2, 5'd2, 16'hFFFF));
    load(4, enc_i(O_ADDIU, 5'd0, 5'd2, 16'h0000));
    load(5, enc_i(O_ADDIU, 5'd2, 5'd2, 16'hFFFF));
    load(6, enc_r(5'd0, 5'd0, 5'd0, 5'd0, FN_JR));
    do_reset();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (register_v0 !== exp[i]) begin
        errors++; $display("FAIL addiu_step%0d: got %h expected %h", i, register_v0, exp[i]);
      end
    end
    checks++;
    if (active !== 1'b0 || instr_address !== 32'h0) begin
      errors++; $display("FAIL addiu_halt: got act=%b pc=%h expected 0 0", active, instr_address);
    end
  endtask

  task automatic test_alu();
    logic [31:0] exp [19] = '{32'h0, 32'h0, 32'h25, 32'h1, 32'h0, 32'hFFFFFFFC, 32'h0FFFFFFF,
                              32'hA8, 32'h0000000A, 32'hFFFF000F, 32'h00008000, 32'h1, 32'h0,
                              32'hFFFFFFF5, 32'h10, 32'hFFFFFFE5, 32'h5, 32'h5, 32'h5};
    clear_mem();
    load(0,  enc_i(O_ADDIU, 5'd0, 5'd3, 16'hFFF0));
    load(1,  enc_i(O_ADDIU, 5'd0, 5'd4, 16'h0015));
    load(2,  enc_r(5'd4, 5'd3, 5'd2, 5'd0, FN_SUBU));
    load(3,  enc_r(5'd3, 5'd4, 5'd2, 5'd0, FN_SLT));
    load(4,  enc_r(5'd3, 5'd4, 5'd2, 5'd0, FN_SLTU));
    load(5,  enc_r(5'd0, 5'd3, 5'd2, 5'd2, FN_SRA));
    load(6,  enc_r(5'd0, 5'd3, 5'd2, 5'd4, FN_SRL));
    load(7,  enc_r(5'd0, 5'd4, 5'd2, 5'd3, FN_SLL));
    load(8,  enc_r(5'd3, 5'd4, 5'd2, 5'd0, FN_NOR));
    load(9,  enc_i(O_XORI, 5'd3, 5'd2, 16'hFFFF));
    load(10, enc_i(O_ANDI, 5'd3, 5'd2, 16'h8001));
    load(11, enc_i(O_SLTIU, 5'd4, 5'd2, 16'hFFFF));
    load(12, enc_i(O_SLTI, 5'd4, 5'd2, 16'hFFFF));
    load(13, enc_r(5'd3, 5'd4, 5'd2, 5'd0, FN_OR));
    load(14, enc_r(5'd3, 5'd4, 5'd2, 5'd0, FN_AND));
    load(15, enc_r(5'd3, 5'd4, 5'd2, 5'd0, FN_XOR));
    load(16, enc_r(5'd3, 5'd4, 5'd2, 5'd0, FN_ADDU));
    load(17, enc_r(5'd0, 5'd0, 5'd0, 5'd0, FN_JR));
    do_reset();
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      checks++;
      if (register_v0 !== exp[i]) begin
        errors++; $display("FAIL alu_step%0d: got %h expected %h", i, register_v0, exp[i]);
      end
    end
    checks++;
    if (active !== 1'b0) begin
      errors++; $display("FAIL alu_halt: got act=%b expected 0", active);
    end
  endtask

  task automatic test_store_loop();
    bit          to;
    logic [31:0] expv;
    clear_mem();
    load(0,  enc_i(O_ADDIU, 5'd0, 5'd5, 16'h0480));
    load(1,  enc_i(O_LUI, 5'd0, 5'd6, 16'h1234));
    load(2,  enc_i(O_ORI, 5'd6, 5'd6, 16'h5679));
    load(3,  enc_i(O_LUI, 5'd0, 5'd7, 16'hDCBA));
    load(4,  enc_i(O_ORI, 5'd7, 5'd7, 16'h1234));
    load(5,  enc_i(O_ADDIU, 5'd0, 5'd8, 16'd30));
    load(6,  enc_i(O_SW, 5'd5, 5'd6, 16'h0000));
    load(7,  enc_r(5'd6, 5'd7, 5'd6, 5'd0, FN_ADDU));
    load(8,  enc_i(O_ADDIU, 5'd5, 5'd5, 16'h0004));
    load(9,  enc_i(O_ADDIU, 5'd8, 5'd8, 16'hFFFF));
    load(10, enc_i(O_BNE, 5'd8, 5'd0, 16'hFFFB));
    load(12, enc_r(5'd0, 5'd0, 5'd0, 5'd0, FN_JR));
    do_reset();
    run_to_halt(400, to);
    checks++;
    if (to) begin
      errors++; $display("FAIL store_loop_halt: got active=%b expected 0 within 400 cycles", active);
    end
    for (int k = 0; k < 30; k++) begin
      expv = 32'h12345678 + 32'(k) * 32'hDCBA1234 + 32'd1;
      checks++;
      if (bswap(dram[32'h120 + k]) !== expv) begin
        errors++;
        $display("FAIL store_word%0d: got %h expected %h", k, bswap(dram[32'h120 + k]), expv);
      end
    end
    checks++;
    if (dram[32'h13E] !== 32'h0) begin
      errors++; $display("FAIL store_past_end: got %h expected 0", dram[32'h13E]);
    end
  endtask

  task automatic test_load_use();
    bit to;
    clear_mem();
    load(0, enc_i(O_LUI, 5'd0, 5'd9, 16'hA1B2));
    load(1, enc_i(O_ORI, 5'd9, 5'd9, 16'hC3D4));
    load(2, enc_i(O_SW, 5'd0, 5'd9, 16'h0100));
    load(3, enc_i(O_LW, 5'd0, 5'd2, 16'h0100));
    load(4, enc_r(5'd0, 5'd0, 5'd0, 5'd0, FN_JR));
    do_reset();
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (data_read !== (i == 3) || data_write !== (i == 2)) begin
        errors++;
        $display("FAIL ldst_strobe%0d: got rd=%b wr=%b expected %b %b", i, data_read,
                 data_write, (i == 3), (i == 2));
      end
      if (i == 2) begin
        checks++;
        if (data_address !== 32'h100 || data_writedata !== 32'hD4C3B2A1) begin
          errors++;
          $display("FAIL sw_bus: got addr=%h data=%h expected 00000100 d4c3b2a1",
                   data_address, data_writedata);
        end
      end
      @(negedge clk);
      if (i == 3) begin
        checks++;
        if (register_v0 !== 32'hA1B2C3D4) begin
          errors++; $display("FAIL lw_v0: got %h expected a1b2c3d4", register_v0);
        end
      end
    end
    run_to_halt(5, to);
    checks++;
    if (to || dram[32'h40] !== 32'hD4C3B2A1) begin
      errors++;
      $display("FAIL ldst_mem: got act=%b word=%h expected 0 d4c3b2a1", active, dram[32'h40]);
    end
  endtask

  task automatic test_branch();
    int          pcs [8] = '{0, 1, 2, 4, 5, 8, 9, 10};
    logic [31:0] exp [8] = '{32'd10, 32'd10, 32'd11, 32'd11, 32'd13, 32'hBFC00018,
                             32'hBFC00018, 32'hBFC00018};
    clear_mem();
    load(0, enc_i(O_ADDIU, 5'd0, 5'd2, 16'd10));
    load(1, enc_i(O_BEQ, 5'd0, 5'd0, 16'd2));
    load(2, enc_i(O_ADDIU, 5'd2, 5'd2, 16'd1));
    load(3, enc_i(O_ADDIU, 5'd2, 5'd2, 16'h0100));
    load(4, enc_j(O_JAL, RV + 32'h20));
    load(5, enc_i(O_ADDIU, 5'd2, 5'd2, 16'd2));
    load(6, enc_i(O_ADDIU, 5'd2, 5'd2, 16'h0100));
    load(8, enc_r(5'd31, 5'd0, 5'd2, 5'd0, FN_ADDU));
    load(9, enc_r(5'd0, 5'd0, 5'd0, 5'd0, FN_JR));
    do_reset();
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (instr_address !== RV + 32'(pcs[i] * 4)) begin
        errors++;
        $display("FAIL branch_pc%0d: got %h expected %h", i, instr_address,
                 RV + 32'(pcs[i] * 4));
      end
      @(negedge clk);
      checks++;
      if (register_v0 !== exp[i]) begin
        errors++; $display("FAIL branch_v0_%0d: got %h expected %h", i, register_v0, exp[i]);
      end
    end
    checks++;
    if (active !== 1'b0) begin
      errors++; $display("FAIL branch_halt: got act=%b expected 0", active);
    end
  endtask

  task automatic test_clk_enable();
    bit to;
    clear_mem();
    load(0, enc_i(O_LUI, 5'd0, 5'd9, 16'hA1B2));
    load(1, enc_i(O_ORI, 5'd9, 5'd9, 16'hC3D4));
    load(2, enc_i(O_SW, 5'd0, 5'd9, 16'h0100));
    load(3, enc_i(O_LW, 5'd0, 5'd2, 16'h0100));
    load(4, enc_r(5'd0, 5'd0, 5'd0, 5'd0, FN_JR));
    do_reset();
    repeat (2) @(negedge clk);
    clk_enable = 1'b0;
    #1;
    checks++;
    if (data_write !== 1'b0) begin
      errors++; $display("FAIL freeze_strobe: got wr=%b expected 0", data_write);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (instr_address !== RV + 32'd8 || register_v0 !== 32'h0 || dram[32'h40] !== 32'h0
          || data_write !== 1'b0) begin
        errors++;
        $display("FAIL freeze%0d: got pc=%h v0=%h mem=%h wr=%b expected %h 0 0 0", i,
                 instr_address, register_v0, dram[32'h40], data_write, RV + 32'd8);
      end
    end
    clk_enable = 1'b1;
    run_to_halt(20, to);
    checks++;
    if (to || register_v0 !== 32'hA1B2C3D4 || dram[32'h40] !== 32'hD4C3B2A1) begin
      errors++;
      $display("FAIL freeze_resume: got act=%b v0=%h mem=%h expected 0 a1b2c3d4 d4c3b2a1",
               active, register_v0, dram[32'h40]);
    end
  endtask

  task automatic test_async_reset();
    clear_mem();
    load(0, enc_i(O_LUI, 5'd0, 5'd2, 16'h1234));
    load(1, enc_i(O_ORI, 5'd2, 5'd2, 16'h5678));
    load(2, enc_i(O_ADDIU, 5'd2, 5'd2, 16'h0001));
    load(3, enc_r(5'd0, 5'd0, 5'd0, 5'd0, FN_JR));
    do_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (register_v0 !== 32'h12345679 || instr_address !== RV + 32'd12) begin
      errors++;
      $display("FAIL areset_pre: got v0=%h pc=%h expected 12345679 %h", register_v0,
               instr_address, RV + 32'd12);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (instr_address !== RV || register_v0 !== 32'h0 || active !== 1'b1) begin
      errors++;
      $display("FAIL areset_now: got pc=%h v0=%h act=%b expected %h 0 1", instr_address,
               register_v0, active, RV);
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (register_v0 !== 32'h12345679) begin
      errors++; $display("FAIL areset_rerun: got %h expected 12345679", register_v0);
    end
  endtask

  initial begin
    reset = 1'b1;
    clk_enable = 1'b1;
    clear_mem();
    test_reset();
    test_addiu();
    test_alu();
    test_store_loop();
    test_load_use();
    test_branch();
    test_clk_enable();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
